// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: state encoding, buffered entry layout and PC alignment.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of {pc, instr} entries between fetch and decode.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves the occupancy unchanged.
      if (do_push && !do_pop)      count_d = count_q + 1'b1;
      else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry;
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, runs one outstanding instr_cache request at a time and
// buffers returned instructions for decode; redirects flush and squash in-flight data.
module instr_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] cpu_addr,
  output logic        cpu_req,
  input  logic [31:0] cpu_rdata,
  input  logic        cpu_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  input  logic        id_ready
);
  fetch_state_t  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   req_addr_q, req_addr_d;
  logic          req_raw, done, push, pop, full, empty;
  fetch_entry_t  push_entry, head;

  assign cpu_req  = req_raw && !rst;
  assign done     = cpu_req && cpu_ready;
  assign if_valid = !empty && !rst;
  assign pop      = if_valid && id_ready;
  assign if_pc    = head.pc;
  assign if_instr = head.instr;
  assign push_entry = '{pc: cpu_addr, instr: cpu_rdata};

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    req_raw    = 1'b0;
    cpu_addr   = pc_q;
    push       = 1'b0;
    case (state_q)
      IDLE: begin
        // Full means no room even if decode pops this cycle, keeping id_ready off cpu_req.
        req_raw = !full && !redirect;
        if (req_raw && cpu_ready) begin
          push = 1'b1;
          pc_d = pc_q + 32'd4;
        end else if (req_raw) begin
          state_d    = WAIT;
          req_addr_d = pc_q;
        end
      end
      WAIT: begin
        req_raw  = 1'b1;
        cpu_addr = req_addr_q;
        if (cpu_ready) begin
          push    = 1'b1;
          pc_d    = req_addr_q + 32'd4;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        req_raw  = 1'b1;
        cpu_addr = req_addr_q;
        if (cpu_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A redirect drops anything returned this cycle; a request still open must drain first.
    if (redirect) begin
      push = 1'b0;
      pc_d = align_pc(redirect_pc);
      if (state_q != IDLE && !cpu_ready) state_d = DISCARD;
      else                               state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (redirect),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );
endmodule
